mem_multi_bank_clear: RTL
=========================

Name: mem_multi_bank_clear

Overview:
- Banked RAM: NUM_BANKS independent banks, each DEPTH x DATA_WIDTH, with one shared write port and one shared read port (bank-select plus address).
- An internal sequencer clears whole banks to DEFAULT_VALUE on request, one entry per cycle.
- Clear requests queue per bank and are serviced lowest-index-first.
- Intended for multi-channel synth state (operator and channel RAMs) where individual channel groups must be wiped without stalling the other banks.

Parameters:
- DATA_WIDTH, 8, bits per entry.
- DEPTH, 16, entries per bank; must be >= 2.
- NUM_BANKS, 4, number of banks; must be >= 1.
- OUTPUT_DELAY, 1, read latency in cycles; legal values 0, 1, 2.
- DEFAULT_VALUE, '0, value written by a clear.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- wea  in  1  write enable
- bank_a  in  $clog2(NUM_BANKS) (min 1)  write bank
- addra  in  $clog2(DEPTH)  write address
- dia  in  DATA_WIDTH  write data
- reb  in  1  read enable; used only when OUTPUT_DELAY > 0
- bank_b  in  $clog2(NUM_BANKS) (min 1)  read bank
- addrb  in  $clog2(DEPTH)  read address
- dob  out  DATA_WIDTH  read data
- clear_req  in  NUM_BANKS  per-bank clear request pulse
- clear_pending  out  NUM_BANKS  queued requests, not yet started
- clear_busy  out  1  sequencer is clearing
- clear_bank  out  $clog2(NUM_BANKS) (min 1)  bank currently being cleared
- clear_done_pulse  out  NUM_BANKS  one-cycle completion strobe per bank

Behaviour:
- Reset values:
  - state = IDLE.
  - clear_pending, clear_busy, clear_bank, clear_done_pulse and the clear address counter all 0.
  - dob pipeline registers reset to DEFAULT_VALUE.
  - RAM contents are not reset.
- Pending mask: pending <= (pending | clear_req) & ~start_mask each cycle. start_mask is the one-hot of the bank chosen when leaving IDLE.
- FSM, IDLE:
  - If pending != 0: select the lowest set bit, latch it into clear_bank, clear that pending bit, set addr = 0, go to CLEARING.
  - Selection happens one cycle after pending becomes nonzero.
- FSM, CLEARING:
  - Write DEFAULT_VALUE to clear_bank[addr].
  - If addr == DEPTH-1: go to IDLE and assert clear_done_pulse[clear_bank] on the next cycle. Otherwise addr++.
- Per-bank clear time:
  - DEPTH cycles of writes.
  - Back-to-back clears cost DEPTH+1 cycles each (one IDLE cycle between them).
- Write arbitration:
  - A user write to bank_a == clear_bank while clear_busy is dropped.
  - User writes to other banks proceed in the same cycle.
- A clear_req for the bank currently being cleared re-queues it; that bank is cleared again after the current pass finishes.
- Reads:
  - OUTPUT_DELAY 0: combinational read.
  - OUTPUT_DELAY 1: registered on reb.
  - OUTPUT_DELAY 2: second register stage, also gated by reb.
  - Read-during-write to the same location returns old data.
- Reset mid-clear:
  - Aborts the clear and drops all pending requests.
  - No done pulse is issued.
  - The partially cleared bank holds mixed contents.
- Simultaneous clear_req on several banks: all are queued and serviced in ascending index order.

Optional Feature:
- Macro: MEM_CLEAR_READ_MASK_EN.
- Defined: a read of bank_b == clear_bank while clear_busy returns DEFAULT_VALUE, regardless of RAM contents. The mask decision is taken at read-issue time and pipelined with the read data, so reads see a coherent "already cleared" bank.
- Undefined: reads during a clear return raw RAM contents (old or cleared, depending on addr).

Decomposition:
- Package mem_clear_pkg holds:
  - the FSM state enum (IDLE, CLEARING);
  - the helper function bank_width(n) = max(1, $clog2(n)).
- Each bank is an instance of the existing mem_single_bank. This top holds the sequencer, write demux and read mux.

Test Plan (NUM_BANKS=4, DEPTH=16, DATA_WIDTH=8, DEFAULT_VALUE=8'hA5, OUTPUT_DELAY=1):
- Fill all banks with bank*16+addr, then pulse clear_req=4'b0100. Required:
  - clear_busy for 16 cycles;
  - clear_done_pulse=4'b0100 for exactly 1 cycle;
  - bank 2 reads 8'hA5 everywhere;
  - banks 0, 1 and 3 unchanged.
- clear_req=4'b1010 in a single cycle. Required:
  - bank 1 cleared first, then bank 3;
  - done pulses 17 cycles apart;
  - clear_pending=4'b1000 during bank 1's clear.
- During bank 0's clear, write 8'h3C to bank 0 addr 5 and to bank 1 addr 5. Required: bank 0[5]=8'hA5, bank 1[5]=8'h3C.
- Re-pulse clear_req[0] at addr 10 of bank 0's clear. Required: a second full 16-cycle clear of bank 0, and two done pulses.
- Assert reset at addr 7 of a clear. Required:
  - busy, pending and done all 0 next cycle;
  - no done pulse;
  - entries 0..6 read 8'hA5, entries 8..15 keep their old data.
- With MEM_CLEAR_READ_MASK_EN, read bank 2 addr 15 during bank 2's clear at addr 3. Required: 8'hA5. Without the macro: the original fill value.

Source files
------------

// File: rtl/mem_clear_pkg.sv
// Shared types and helpers for the banked RAM with per-bank clear sequencer.
package mem_clear_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StClearing
    } clear_state_t;

    // Bank-select width; never narrower than one bit so a single bank still has a port.
    function automatic int unsigned bank_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_single_bank.sv
// One RAM bank: single write port, asynchronous read port (old data on read-during-write).
module mem_single_bank #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_multi_bank_clear.sv
// Banked RAM with a background sequencer that wipes whole banks to DEFAULT_VALUE.
// Optional macro MEM_CLEAR_READ_MASK_EN: reads of the bank being cleared return DEFAULT_VALUE.
module mem_multi_bank_clear
    import mem_clear_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH    = 8,
    parameter int unsigned           DEPTH         = 16,
    parameter int unsigned           NUM_BANKS     = 4,
    parameter int unsigned           OUTPUT_DELAY  = 1,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_VALUE = '0
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                wea,
    input  logic [bank_width(NUM_BANKS)-1:0]    bank_a,
    input  logic [$clog2(DEPTH)-1:0]            addra,
    input  logic [DATA_WIDTH-1:0]               dia,
    input  logic                                reb,
    input  logic [bank_width(NUM_BANKS)-1:0]    bank_b,
    input  logic [$clog2(DEPTH)-1:0]            addrb,
    output logic [DATA_WIDTH-1:0]               dob,
    input  logic [NUM_BANKS-1:0]                clear_req,
    output logic [NUM_BANKS-1:0]                clear_pending,
    output logic                                clear_busy,
    output logic [bank_width(NUM_BANKS)-1:0]    clear_bank,
    output logic [NUM_BANKS-1:0]                clear_done_pulse
);

    localparam int unsigned BW = bank_width(NUM_BANKS);
    localparam int unsigned AW = $clog2(DEPTH);

    clear_state_t          state;
    logic [AW-1:0]         addr;
    logic [BW-1:0]         next_bank;
    logic [NUM_BANKS-1:0]  start_mask;
    logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];
    logic [DATA_WIDTH-1:0] rd_raw;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_mask;

    // Lowest-index pending bank wins.
    always_comb begin
        next_bank = '0;
        for (int i = int'(NUM_BANKS) - 1; i >= 0; i--) begin
            if (clear_pending[i]) begin
                next_bank = BW'(i);
            end
        end
    end

    always_comb begin
        start_mask = '0;
        if (state == StIdle && |clear_pending) begin
            start_mask = NUM_BANKS'(1) << next_bank;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= StIdle;
            addr             <= '0;
            clear_pending    <= '0;
            clear_busy       <= 1'b0;
            clear_bank       <= '0;
            clear_done_pulse <= '0;
        end else begin
            clear_pending    <= (clear_pending | clear_req) & ~start_mask;
            clear_done_pulse <= '0;
            unique case (state)
                StIdle: begin
                    if (|clear_pending) begin
                        clear_bank <= next_bank;
                        addr       <= '0;
                        clear_busy <= 1'b1;
                        state      <= StClearing;
                    end
                end
                StClearing: begin
                    if (addr == AW'(DEPTH - 1)) begin
                        state            <= StIdle;
                        clear_busy       <= 1'b0;
                        clear_done_pulse <= NUM_BANKS'(1) << clear_bank;
                    end else begin
                        addr <= addr + AW'(1);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic          is_clear;
        logic          user_we;
        logic          we;
        logic [AW-1:0] waddr;
        logic [DATA_WIDTH-1:0] wdata;

        assign is_clear = clear_busy && (clear_bank == BW'(b));
        // The sequencer owns its bank; user writes to it are dropped.
        assign user_we  = wea && (bank_a == BW'(b)) && !is_clear;
        assign we       = !reset && (is_clear || user_we);
        assign waddr    = is_clear ? addr : addra;
        assign wdata    = is_clear ? DEFAULT_VALUE : dia;

        mem_single_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_bank (
            .clk   (clk),
            .we    (we),
            .waddr (waddr),
            .wdata (wdata),
            .raddr (addrb),
            .rdata (bank_rdata[b])
        );
    end

    always_comb begin
        rd_raw = DEFAULT_VALUE;
        for (int i = 0; i < int'(NUM_BANKS); i++) begin
            if (bank_b == BW'(i)) begin
                rd_raw = bank_rdata[i];
            end
        end
    end

`ifdef MEM_CLEAR_READ_MASK_EN
    // Decided at issue time so the mask travels down the pipe with its data.
    assign rd_mask = clear_busy && (bank_b == clear_bank);
`else
    assign rd_mask = 1'b0;
`endif

    assign rd_data = rd_mask ? DEFAULT_VALUE : rd_raw;

    if (OUTPUT_DELAY == 0) begin : g_comb
        assign dob = rd_data;
    end else if (OUTPUT_DELAY == 1) begin : g_reg1
        logic [DATA_WIDTH-1:0] stage1;
        always_ff @(posedge clk) begin
            if (reset) begin
                stage1 <= DEFAULT_VALUE;
            end else if (reb) begin
                stage1 <= rd_data;
            end
        end
        assign dob = stage1;
    end else begin : g_reg2
        logic [DATA_WIDTH-1:0] stage1;
        logic [DATA_WIDTH-1:0] stage2;
        always_ff @(posedge clk) begin
            if (reset) begin
                stage1 <= DEFAULT_VALUE;
                stage2 <= DEFAULT_VALUE;
            end else if (reb) begin
                stage1 <= rd_data;
                stage2 <= stage1;
            end
        end
        assign dob = stage2;
    end

endmodule
